// File: rtl/step_motor_pkg.sv
// Shared definitions for the step-motor speed-ramp slice: default widths,
// speed-table read latency and FSM state encodings.
package step_motor_pkg;

    localparam int C_STEP_NUMBER_WIDTH_DEF   = 16;
    localparam int C_SPEED_DATA_WIDTH_DEF    = 16;
    localparam int C_SPEED_ADDRESS_WIDTH_DEF = 9;

    // Speed-table block RAM returns data one clock after the read enable;
    // the WAIT state exists to absorb exactly this latency.
    localparam int C_RD_LATENCY = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FETCH   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_PRESENT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/step_ramp_index.sv
// Registered speed-table index calculator. Holds the issued-step count, the
// index of the word currently in flight and the sticky stop flag, and works
// out the index of the next word: min(issued, N-1-issued, L-1), further
// clamped to one below the previous index while a stop is in progress.
module step_ramp_index
    import step_motor_pkg::*;
#(
    parameter int C_STEP_NUMBER_WIDTH   = C_STEP_NUMBER_WIDTH_DEF,
    parameter int C_SPEED_ADDRESS_WIDTH = C_SPEED_ADDRESS_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             i_load,
    input  logic                             i_advance,
    input  logic                             i_last,
    input  logic                             i_stop,
    input  logic                             i_clear,
    input  logic [C_STEP_NUMBER_WIDTH-1:0]   i_step_nbr,
    input  logic [C_SPEED_ADDRESS_WIDTH-1:0] i_ramp_len,
    output logic [C_STEP_NUMBER_WIDTH-1:0]   o_issued,
    output logic [C_SPEED_ADDRESS_WIDTH-1:0] o_idx,
    output logic                             o_stopping
);

    localparam int SW = C_STEP_NUMBER_WIDTH;
    localparam int AW = C_SPEED_ADDRESS_WIDTH;
    localparam logic [SW-1:0] ONE_S = {{(SW-1){1'b0}}, 1'b1};

    logic [SW-1:0] issued_r;
    logic [AW-1:0] idx_r;
    logic          stopping_r;

    logic [SW-1:0] issued_next_s;
    logic [SW-1:0] ramp_down_s;
    logic [SW-1:0] ramp_top_s;
    logic [SW-1:0] norm_s;
    logic [SW-1:0] clamp_s;
    logic [SW-1:0] next_idx_s;

    function automatic logic [SW-1:0] min2(input logic [SW-1:0] a, input logic [SW-1:0] b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Index of the word fetched after the current one is handed over.
    always_comb begin
        issued_next_s = issued_r + ONE_S;
        ramp_down_s   = i_step_nbr - ONE_S - issued_next_s;
        ramp_top_s    = SW'(i_ramp_len) - ONE_S;
        norm_s        = min2(min2(issued_next_s, ramp_down_s), ramp_top_s);
        if (idx_r == {AW{1'b0}}) begin
            clamp_s = {SW{1'b0}};
        end else begin
            clamp_s = SW'(idx_r) - ONE_S;
        end
        // A stop landing on this very handshake already shapes the next fetch.
        if (stopping_r | i_stop) begin
            next_idx_s = min2(clamp_s, norm_s);
        end else begin
            next_idx_s = norm_s;
        end
    end

    // Step counter, current index and sticky stop flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued_r   <= {SW{1'b0}};
            idx_r      <= {AW{1'b0}};
            stopping_r <= 1'b0;
        end else if (i_load) begin
            issued_r   <= {SW{1'b0}};
            idx_r      <= {AW{1'b0}};
            stopping_r <= 1'b0;
        end else begin
            if (i_clear) begin
                stopping_r <= 1'b0;
            end else if (i_stop) begin
                stopping_r <= 1'b1;
            end
            if (i_advance) begin
                issued_r <= issued_next_s;
                // After the final word the index holds its last value.
                if (!i_last) begin
                    idx_r <= AW'(next_idx_s);
                end
            end
        end
    end

    assign o_issued   = issued_r;
    assign o_idx      = idx_r;
    assign o_stopping = stopping_r;

endmodule

// File: rtl/step_speed_ramp.sv
// Trapezoidal move sequencer feeding the step-motor pulse driver. For each of
// N steps it reads a period word from the speed table (index 0 = slowest) and
// offers it downstream on a valid/ready handshake; supports graceful stop.
// Optional build macro STEP_SPEED_RAMP_STATS_EN adds o_steps_issued and
// o_cur_index status outputs.
module step_speed_ramp
    import step_motor_pkg::*;
#(
    parameter int C_STEP_NUMBER_WIDTH   = C_STEP_NUMBER_WIDTH_DEF,
    parameter int C_SPEED_DATA_WIDTH    = C_SPEED_DATA_WIDTH_DEF,
    parameter int C_SPEED_ADDRESS_WIDTH = C_SPEED_ADDRESS_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             i_start,
    input  logic                             i_stop,
    input  logic [C_STEP_NUMBER_WIDTH-1:0]   i_step_nbr,
    input  logic [C_SPEED_ADDRESS_WIDTH-1:0] i_ramp_len,
    output logic                             o_rd_en,
    output logic [C_SPEED_ADDRESS_WIDTH-1:0] o_rd_addr,
    input  logic [C_SPEED_DATA_WIDTH-1:0]    i_rd_data,
    output logic                             o_period_valid,
    input  logic                             i_period_ready,
    output logic [C_SPEED_DATA_WIDTH-1:0]    o_period,
    output logic                             o_last,
    output logic                             o_busy,
    output logic                             o_done
`ifdef STEP_SPEED_RAMP_STATS_EN
    ,
    output logic [C_STEP_NUMBER_WIDTH-1:0]   o_steps_issued,
    output logic [C_SPEED_ADDRESS_WIDTH-1:0] o_cur_index
`endif
);

    localparam int SW = C_STEP_NUMBER_WIDTH;
    localparam int DW = C_SPEED_DATA_WIDTH;
    localparam int AW = C_SPEED_ADDRESS_WIDTH;
    localparam logic [SW-1:0] ONE_S = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [SW-1:0] step_nbr_r;
    logic [AW-1:0] ramp_len_r;
    logic          rd_en_r;
    logic [DW-1:0] period_r;
    logic          valid_r;
    logic          last_r;
    logic          busy_r;
    logic          done_r;

    logic          start_s;
    logic          stop_s;
    logic          hs_s;
    logic          final_s;
    logic          floor_s;
    logic          stop_any_s;
    logic          clear_s;
    logic [SW-1:0] issued_s;
    logic [AW-1:0] idx_s;
    logic          stopping_s;

    // Per-cycle strobes: accepted start/stop, handshake and last-word terms.
    always_comb begin
        start_s    = (state_r == ST_IDLE) & i_start;
        stop_s     = i_stop & busy_r;
        hs_s       = (state_r == ST_PRESENT) & valid_r & i_period_ready;
        clear_s    = (state_r == ST_DONE);
        final_s    = (issued_s == (step_nbr_r - ONE_S));
        floor_s    = (idx_s == {AW{1'b0}});
        stop_any_s = stopping_s | stop_s;
    end

    step_ramp_index #(
        .C_STEP_NUMBER_WIDTH   (SW),
        .C_SPEED_ADDRESS_WIDTH (AW)
    ) u_index (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (start_s),
        .i_advance  (hs_s),
        .i_last     (last_r),
        .i_stop     (stop_s),
        .i_clear    (clear_s),
        .i_step_nbr (step_nbr_r),
        .i_ramp_len (ramp_len_r),
        .o_issued   (issued_s),
        .o_idx      (idx_s),
        .o_stopping (stopping_s)
    );

    // Move sequencer: FETCH -> WAIT -> PRESENT per word, all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            step_nbr_r <= {SW{1'b0}};
            ramp_len_r <= {AW{1'b0}};
            rd_en_r    <= 1'b0;
            period_r   <= {DW{1'b0}};
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (i_step_nbr == {SW{1'b0}}) begin
                            // Empty move: completes at once without busy.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            step_nbr_r <= i_step_nbr;
                            ramp_len_r <= (i_ramp_len == {AW{1'b0}}) ? ONE_A : i_ramp_len;
                            busy_r     <= 1'b1;
                            rd_en_r    <= 1'b1;
                            state_r    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_en_r <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    period_r <= i_rd_data;
                    valid_r  <= 1'b1;
                    last_r   <= final_s | (stop_any_s & floor_s);
                    state_r  <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (hs_s) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        if (last_r) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            rd_en_r <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        // Stop while parked at the slowest entry ends the move here.
                        last_r <= last_r | (stop_s & floor_s);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_en        = rd_en_r;
    assign o_rd_addr      = idx_s;
    assign o_period_valid = valid_r;
    assign o_period       = period_r;
    assign o_last         = last_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;

`ifdef STEP_SPEED_RAMP_STATS_EN
    assign o_steps_issued = issued_s;
    assign o_cur_index    = idx_s;
`endif

endmodule

// File: tb/tb_step_speed_ramp.sv
// Self-checking bench for step_speed_ramp: directed moves plus randomized
// moves, compared against a per-word reference model of the ramp profile.
`timescale 1ns/1ps
module tb_step_speed_ramp;

    localparam int SW = 16;
    localparam int DW = 16;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_start;
    logic          i_stop;
    logic [SW-1:0] i_step_nbr;
    logic [AW-1:0] i_ramp_len;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] rd_data;
    logic          o_period_valid;
    logic          i_period_ready;
    logic [DW-1:0] o_period;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
`ifdef STEP_SPEED_RAMP_STATS_EN
    logic [SW-1:0] steps_issued;
    logic [AW-1:0] cur_index;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] tbl [0:511];
    int            exp_idx[$];
    bit            exp_last[$];

    always #5 clk = ~clk;

    step_speed_ramp dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_step_nbr     (i_step_nbr),
        .i_ramp_len     (i_ramp_len),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (rd_data),
        .o_period_valid (o_period_valid),
        .i_period_ready (i_period_ready),
        .o_period       (o_period),
        .o_last         (o_last),
        .o_busy         (o_busy),
        .o_done         (o_done)
`ifdef STEP_SPEED_RAMP_STATS_EN
        ,
        .o_steps_issued (steps_issued),
        .o_cur_index    (cur_index)
`endif
    );

    // Speed-table block RAM model, one clock read latency.
    always @(posedge clk) begin
        if (o_rd_en) rd_data <= tbl[o_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference profile. mode 0: stop coincides with handshake of word w;
    // mode 1: stop arrives while word w is presented; mode 2: no stop.
    function automatic void build_model(input int n, input int l, input int w, input int mode);
        int  le, prev, idx, c;
        bit  stopping, last;
        exp_idx.delete();
        exp_last.delete();
        le = (l == 0) ? 1 : l;
        prev = 0;
        stopping = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = k;
            if (n - 1 - k < idx) idx = n - 1 - k;
            if (le - 1 < idx) idx = le - 1;
            if (stopping) begin
                c = (prev > 0) ? prev - 1 : 0;
                if (c < idx) idx = c;
            end
            if (mode == 1 && k == w) stopping = 1'b1;
            last = (k == n - 1) || (stopping && idx == 0);
            exp_idx.push_back(idx);
            exp_last.push_back(last);
            prev = idx;
            if (last) break;
            if (mode == 0 && k == w) stopping = 1'b1;
        end
    endfunction

    task automatic run_move(input string name, input int n, input int l, input int w, input int mode,
                            input int stall_w, input int stall_len, input bit rnd, input int busy_start);
        int cyc, words, stall_cnt, done_cnt, done_cyc, last_hs_cyc, first_valid, tail, lim;
        bit stall_prev, stop_prev, finished;
        logic [DW-1:0] prev_period;
        logic prev_last;
        int got_addr[$];
        int got_period[$];
        int got_last[$];
        build_model(n, l, w, mode);
        words = 0; stall_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -100;
        first_valid = -1; tail = 0; stall_prev = 1'b0; stop_prev = 1'b0; finished = 1'b0;
        prev_period = '0; prev_last = 1'b0;
        @(negedge clk);
        i_step_nbr = SW'(n);
        i_ramp_len = AW'(l);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (!finished) begin
            if (cyc == 1) check({name, " busy"}, o_busy, 1);
            if (stall_prev) begin
                check({name, " stall valid"}, o_period_valid, 1);
                check({name, " stall period"}, o_period, prev_period);
                if (!stop_prev) check({name, " stall last"}, o_last, prev_last);
            end
            if (o_rd_en) got_addr.push_back(int'(o_rd_addr));
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_period_valid && first_valid < 0) first_valid = cyc;
            i_stop = 1'b0;
            i_start = 1'b0;
            if (o_period_valid && words == stall_w && stall_cnt < stall_len) begin
                i_period_ready = 1'b0;
                stall_cnt++;
                if (mode == 1 && words == w && stall_cnt == 2) i_stop = 1'b1;
            end else begin
                i_period_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mode == 0 && o_period_valid && i_period_ready && words == w) i_stop = 1'b1;
            if (cyc == busy_start) begin i_start = 1'b1; i_step_nbr = SW'(3); end
            stall_prev = o_period_valid && !i_period_ready;
            stop_prev = i_stop;
            prev_period = o_period;
            prev_last = o_last;
            if (o_period_valid && i_period_ready) begin
                got_period.push_back(int'(o_period));
                got_last.push_back(int'(o_last));
                words++;
                if (o_last) last_hs_cyc = cyc;
            end
            if (done_cnt > 0) tail++;
            if (tail > 3 || cyc >= 3000) finished = 1'b1;
            @(negedge clk);
            cyc++;
        end
        i_period_ready = 1'b1; i_stop = 1'b0; i_start = 1'b0;
        check({name, " done seen in budget"}, done_cnt > 0, 1);
        check({name, " word count"}, words, exp_idx.size());
        check({name, " read count"}, got_addr.size(), exp_idx.size());
        lim = (words < exp_idx.size()) ? words : exp_idx.size();
        for (int k = 0; k < lim; k++) begin
            check($sformatf("%s word%0d period", name, k), got_period[k], int'(tbl[exp_idx[k]]));
            check($sformatf("%s word%0d last", name, k), got_last[k], int'(exp_last[k]));
        end
        lim = (got_addr.size() < exp_idx.size()) ? got_addr.size() : exp_idx.size();
        for (int k = 0; k < lim; k++)
            check($sformatf("%s read%0d addr", name, k), got_addr[k], exp_idx[k]);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " done timing"}, done_cyc, last_hs_cyc + 1);
        check({name, " first valid cycle"}, first_valid, 3);
        check({name, " idle busy"}, o_busy, 0);
    endtask

    initial begin
        int hs, n, l, w, mode;
        for (int i = 0; i < 512; i++)
            tbl[i] = (i < 10) ? DW'(1000 - 100 * i) : DW'(3000 + 13 * i);
        resetn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_period_ready = 1'b1;
        i_step_nbr = '0; i_ramp_len = '0;
        #12;
        check("reset valid", o_period_valid, 0);
        check("reset rd_en", o_rd_en, 0);
        check("reset rd_addr", o_rd_addr, 0);
        check("reset period", o_period, 0);
        check("reset last", o_last, 0);
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_move("profile", 5, 4, 0, 2, -1, 0, 1'b0, 0);
        run_move("cruise", 10, 3, 0, 2, -1, 0, 1'b0, 0);
        run_move("gstop", 20, 8, 4, 0, -1, 0, 1'b0, 0);
        run_move("backpressure", 6, 3, 0, 2, 1, 7, 1'b0, 0);
        run_move("len0", 3, 0, 0, 2, -1, 0, 1'b0, 0);
        run_move("start_busy", 8, 4, 0, 2, -1, 0, 1'b0, 5);
        run_move("stop_at_floor", 5, 4, 0, 1, 0, 4, 1'b0, 0);
        run_move("stop_final", 4, 2, 3, 0, -1, 0, 1'b0, 0);
        run_move("long_ramp", 7, 9, 0, 2, -1, 0, 1'b0, 0);

        // Zero-length move: done next cycle, never valid, never busy.
        @(negedge clk);
        i_step_nbr = '0; i_ramp_len = AW'(4); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("n0 done", o_done, 1);
        check("n0 busy", o_busy, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("n0 no valid", o_period_valid, 0);
            check("n0 no read", o_rd_en, 0);
            check("n0 single done", o_done, 0);
        end

        // Reset while the third word is presented.
        @(negedge clk);
        i_step_nbr = SW'(10); i_ramp_len = AW'(4); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_period_ready = 1'b1; hs = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_period_valid) begin
                if (hs == 2) begin i_period_ready = 1'b0; break; end
                hs++;
            end
            @(negedge clk);
        end
        check("rst word3 presented", o_period_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("rst async valid", o_period_valid, 0);
        check("rst async busy", o_busy, 0);
        check("rst async last", o_last, 0);
        check("rst async period", o_period, 0);
        check("rst async rd_en", o_rd_en, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst no done", o_done, 0);
        end
        resetn = 1'b1;
        i_period_ready = 1'b1;
        run_move("after_reset", 5, 4, 0, 2, -1, 0, 1'b0, 0);

        // Randomized moves with random backpressure and stop placement.
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 30));
            l = int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 2));
            w = int'($urandom_range(0, n - 1));
            if (mode == 1)
                run_move($sformatf("rand%0d", r), n, l, w, mode, w, 3, 1'b1, 0);
            else
                run_move($sformatf("rand%0d", r), n, l, w, mode, -1, 0, 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
